// File: rtl/hgcal_latent_unpacker_pkg.sv
// Shared definitions for the HGCAL latent-code link and decoder layers.
// Holds default geometry, the unpacker FSM states and a code extractor.
package hgcal_latent_pkg;

    localparam int CODE_W   = 2;
    localparam int N_LATENT = 16;
    localparam int LINK_W   = 8;
    localparam int CPW      = LINK_W / CODE_W;
    localparam int NWORDS   = N_LATENT / CPW;
    localparam int VEC_W    = N_LATENT * CODE_W;

    typedef enum logic [1:0] {
        HUNT,
        COLLECT,
        FULL
    } state_t;

    // Code i of a packed latent vector, lsb code first.
    function automatic logic [CODE_W-1:0] code_slice(
        input logic [VEC_W-1:0] vec,
        input int               i
    );
        return vec[i*CODE_W +: CODE_W];
    endfunction

endpackage

// File: rtl/hgcal_latent_unpacker_if.sv
// Valid/ready stream bundle used for the link input and vector output.
// Ports: valid, ready, data[W], first (frame start marker).
interface hgcal_latent_unpacker_if #(
    parameter int W = hgcal_latent_pkg::LINK_W
) ();

    logic         valid;
    logic         ready;
    logic         first;
    logic [W-1:0] data;

    modport master (
        output valid,
        output data,
        output first,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  first,
        output ready
    );

endinterface

// File: rtl/hgcal_latent_outreg.sv
// One-entry output register holding a latent vector for the decoder.
// Ports: load/din from assembler, ready from sink, valid/data/free out.
module hgcal_latent_outreg #(
    parameter int W = hgcal_latent_pkg::VEC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         free
);

    // Empty, or drained on this very edge.
    assign free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hgcal_latent_unpacker.sv
// Reassembles link words into one packed latent vector per frame.
// Ports: clk, rst_n, s (link in), m (vector out), sync_err, err_count.
module hgcal_latent_unpacker #(
    parameter int N_LATENT = hgcal_latent_pkg::N_LATENT,
    parameter int CODE_W   = hgcal_latent_pkg::CODE_W,
    parameter int LINK_W   = hgcal_latent_pkg::LINK_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hgcal_latent_unpacker_if.slave  s,
    hgcal_latent_unpacker_if.master m,
    output logic                  sync_err,
    output logic [7:0]            err_count
);

    import hgcal_latent_pkg::*;

    localparam int VEC_W  = N_LATENT * CODE_W;
    localparam int NWORDS = VEC_W / LINK_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

    state_t             state;
    state_t             cur;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   widx;
    logic [VEC_W-1:0]   asm_q;
    logic               live;
    logic               s_rdy;
    logic               out_free;
    logic               out_valid;
    logic [VEC_W-1:0]   out_data;
    logic               accept;
    logic               handoff;
    logic               start;
    logic               cont;
    logic               err;
    logic               last;

    // live keeps s_ready low until the first edge after reset.
    assign s_rdy   = live && ((state != FULL) || out_free);
    assign s.ready = s_rdy;

    always_comb begin
        accept  = s.valid && s_rdy;
        handoff = (state == FULL) && out_free;
        // A handoff cycle treats the incoming beat as if in HUNT.
        cur     = handoff ? HUNT : state;
        start   = accept && s.first && (cur != FULL);
        cont    = accept && !s.first && (cur == COLLECT);
        err     = accept &&
                  (((cur == HUNT) && !s.first) ||
                   ((cur == COLLECT) && s.first));
        widx    = start ? '0 : idx;
        last    = (widx == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live      <= 1'b0;
            state     <= HUNT;
            idx       <= '0;
            asm_q     <= '0;
            sync_err  <= 1'b0;
            err_count <= '0;
        end else begin
            live     <= 1'b1;
            sync_err <= err;
            if (err && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;

            // A new frame clears any stale partial content.
            if (start) begin
                asm_q <= VEC_W'(s.data);
            end else if (cont) begin
                for (int k = 0; k < NWORDS; k++)
                    if (idx == IDX_W'(k))
                        asm_q[k*LINK_W +: LINK_W] <= s.data;
            end

            if (start || cont) begin
                state <= last ? FULL : COLLECT;
                idx   <= last ? '0 : widx + 1'b1;
            end else if (handoff) begin
                state <= HUNT;
                idx   <= '0;
            end
        end
    end

    hgcal_latent_outreg #(
        .W (VEC_W)
    ) u_outreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (handoff),
        .din   (asm_q),
        .ready (m.ready),
        .valid (out_valid),
        .data  (out_data),
        .free  (out_free)
    );

    assign m.valid = out_valid;
    assign m.data  = out_data;
    assign m.first = 1'b0;

endmodule
